// File: rtl/w5300_access_arbiter_if.sv
// Command/requester bundle between the W5300 access arbiter, the host-bus
// interface block and the two requesters (port 0 config engine, port 1 data mover).
interface w5300_access_arbiter_if;
  logic [10:0]      ctrl_addr;
  logic [15:0]      ctrl_wr_data;
  logic [15:0]      ctrl_rd_data;
  logic             ctrl_op_state;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_write;
  logic [1:0][9:0]  req_addr;
  logic [1:0][15:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [15:0]      rsp_rdata;
  logic             init_done;
  logic             busy;

  modport master (
    output ctrl_addr, ctrl_wr_data,
    input  ctrl_rd_data, ctrl_op_state,
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, init_done, busy
  );

  modport slave (
    input  ctrl_addr, ctrl_wr_data,
    output ctrl_rd_data, ctrl_op_state,
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, init_done, busy
  );
endinterface

// File: rtl/w5300_access_arbiter.sv
// Shares the W5300 host-bus interface between two requesters: one register access
// per bus cycle, round-robin grant, parked read of PARK_ADDR when nobody asks.
module w5300_access_arbiter #(
  parameter logic [9:0] PARK_ADDR = 10'h000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  w5300_access_arbiter_if.master bus
);

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_PARK,
    ST_BUSY
  } state_t;

  state_t      state_q;
  logic        owner_q;
  logic        owner_write_q;
  logic        last_grant_q;
  logic [10:0] ctrl_addr_q;
  logic [15:0] ctrl_wr_data_q;
  logic [1:0]  rsp_valid_q;
  logic [15:0] rsp_rdata_q;
  logic        init_done_q;
  logic        busy_q;

  logic        grant_any_d;
  logic        grant_port_d;
  logic        sel_write_d;
  logic [9:0]  sel_addr_d;
  logic [15:0] sel_wdata_d;

  // Contention goes to the port that did not win last; a lone requester always wins.
  always_comb begin
    grant_any_d  = |bus.req_valid;
    grant_port_d = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
    sel_write_d  = bus.req_write[grant_port_d];
    sel_addr_d   = bus.req_addr[grant_port_d];
    sel_wdata_d  = bus.req_wdata[grant_port_d];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign bus.req_ready[gi] = bus.ctrl_op_state & grant_any_d & (grant_port_d == (gi == 1));
  end

  // Commands only move on the edge closing an Idle strobe, so they are stable
  // for the whole ReadWrite phase of the interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_BOOT;
      owner_q        <= 1'b0;
      owner_write_q  <= 1'b0;
      last_grant_q   <= 1'b1;
      ctrl_addr_q    <= {OP_RD, PARK_ADDR};
      ctrl_wr_data_q <= '0;
      rsp_valid_q    <= '0;
      rsp_rdata_q    <= '0;
      init_done_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      if (bus.ctrl_op_state) begin
        init_done_q <= 1'b1;
        if (state_q == ST_BUSY) begin
          rsp_valid_q[owner_q] <= 1'b1;
          rsp_rdata_q          <= owner_write_q ? 16'h0000 : bus.ctrl_rd_data;
        end
        if (grant_any_d) begin
          ctrl_addr_q    <= {sel_write_d ? OP_WR : OP_RD, sel_addr_d};
          ctrl_wr_data_q <= sel_write_d ? sel_wdata_d : 16'h0000;
          owner_q        <= grant_port_d;
          owner_write_q  <= sel_write_d;
          last_grant_q   <= grant_port_d;
          state_q        <= ST_BUSY;
          busy_q         <= 1'b1;
        end else begin
          ctrl_addr_q    <= {OP_RD, PARK_ADDR};
          ctrl_wr_data_q <= '0;
          owner_write_q  <= 1'b0;
          state_q        <= ST_PARK;
          busy_q         <= 1'b0;
        end
      end
    end
  end

  assign bus.ctrl_addr    = ctrl_addr_q;
  assign bus.ctrl_wr_data = ctrl_wr_data_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.init_done    = init_done_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_w5300_access_arbiter.sv
// Randomized scoreboard bench for w5300_access_arbiter with a simple W5300 host-bus
// interface model (fixed-length bus cycles, one-cycle Idle strobe, register array).
module tb_w5300_access_arbiter;
  localparam int PERIOD   = 5;
  localparam int BOOT_CYC = 7;
  localparam bit OP_WR    = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  w5300_access_arbiter_if bus ();

  w5300_access_arbiter #(.PARK_ADDR(10'h000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic        v0 = 0, v1 = 0, w0 = 0, w1 = 0;
  logic [9:0]  a0 = 0, a1 = 0;
  logic [15:0] d0 = 0, d1 = 0;
  assign bus.req_valid = {v1, v0};
  assign bus.req_write = {w1, w0};
  assign bus.req_addr  = {a1, a0};
  assign bus.req_wdata = {d1, d0};

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [15:0] dev_mem [1024];
  logic [15:0] ref_mem [1024];

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];
  int   last_grant = 1;
  int   grant_log[$];

  logic [9:0]  last_wr_addr = 0;
  logic [15:0] last_wr_data = 0;
  int          bus_wr_count = 0;
  logic [10:0] phase_addr = 0;
  logic [15:0] phase_wdata = 0;
  bit          have_phase = 0;
  bit          prev_strobe = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Interface model: boot delay after reset, then an Idle strobe every PERIOD cycles.
  int bus_cnt = PERIOD - 1;
  int boot = BOOT_CYC;
  initial begin
    bus.ctrl_op_state = 1'b0;
    bus.ctrl_rd_data  = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        boot = BOOT_CYC;
        bus_cnt = PERIOD - 1;
        bus.ctrl_op_state = 1'b0;
      end else if (boot > 0) begin
        boot--;
        bus.ctrl_op_state = 1'b0;
      end else begin
        bus_cnt = (bus_cnt == PERIOD - 1) ? 0 : bus_cnt + 1;
        bus.ctrl_op_state = (bus_cnt == 0);
      end
      bus.ctrl_rd_data = dev_mem[bus.ctrl_addr[9:0]];
    end
  end

  // Monitor: accepts feed the reference model, responses are popped and compared.
  initial forever begin
    int   p;
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (bus.req_ready != 2'b00) begin
        p = bus.req_ready[1] ? 1 : 0;
        check("ready_in_idle", bus.ctrl_op_state, 1'b1);
        check("ready_onehot", $countones(bus.req_ready), 1);
        check("ready_has_valid", bus.req_valid[p], 1'b1);
        if (bus.req_valid == 2'b11) check("fair_grant", p, 1 - last_grant);
        e.due = cyc + PERIOD + 1;
        if (bus.req_write[p]) begin
          ref_mem[bus.req_addr[p]] = bus.req_wdata[p];
          e.data = 16'h0000;
        end else begin
          e.data = ref_mem[bus.req_addr[p]];
        end
        if (p == 0) sb0.push_back(e);
        else sb1.push_back(e);
        last_grant = p;
        grant_log.push_back(p);
      end
      if (bus.rsp_valid != 2'b00) begin
        check("rsp_onehot", $countones(bus.rsp_valid), 1);
        p = bus.rsp_valid[1] ? 1 : 0;
        compared++;
        if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
          mismatched++;
          $display("FAIL spurious_rsp: port %0d pulsed rsp_valid, expected no response", p);
        end else begin
          e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.data);
          check("rsp_latency", cyc, e.due);
          $display("txn port%0d rsp rdata=%h cycle=%0d", p, bus.rsp_rdata, cyc);
        end
      end
      if (bus.ctrl_op_state) begin
        if (have_phase && bus.ctrl_addr[10] == OP_WR) begin
          dev_mem[bus.ctrl_addr[9:0]] = bus.ctrl_wr_data;
          last_wr_addr = bus.ctrl_addr[9:0];
          last_wr_data = bus.ctrl_wr_data;
          bus_wr_count++;
        end
        have_phase = 1;
        prev_strobe = 1;
      end else if (have_phase) begin
        if (prev_strobe) begin
          phase_addr  = bus.ctrl_addr;
          phase_wdata = bus.ctrl_wr_data;
        end else begin
          check("addr_stable", bus.ctrl_addr, phase_addr);
          check("wdata_stable", bus.ctrl_wr_data, phase_wdata);
        end
        prev_strobe = 0;
      end
    end else begin
      have_phase = 0;
      prev_strobe = 0;
    end
  end

  task automatic set_req(input int p, input bit v, input bit w, input logic [9:0] a,
                         input logic [15:0] d);
    if (p == 0) begin
      v0 = v; w0 = w; a0 = a; d0 = d;
    end else begin
      v1 = v; w1 = w; a1 = a; d1 = d;
    end
  endtask

  // Holds a request for up to 'hold' cycles; reports acceptance and strobes seen.
  task automatic req(input int p, input bit w, input logic [9:0] a, input logic [15:0] d,
                     input int hold, output bit acc, output int strobes);
    @(posedge clk);
    #1;
    set_req(p, 1'b1, w, a, d);
    acc = 0;
    strobes = 0;
    for (int i = 0; i < hold && !acc; i++) begin
      @(negedge clk);
      if (bus.ctrl_op_state) strobes++;
      if (bus.req_ready[p]) acc = 1;
    end
    @(posedge clk);
    #1;
    set_req(p, 1'b0, 1'b0, 10'h0, 16'h0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (sb0.size() + sb1.size()) != 0; i++) @(negedge clk);
    check("drain", sb0.size() + sb1.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl_addr"}, bus.ctrl_addr, 11'h000);
    check({tag, "_wr_data"}, bus.ctrl_wr_data, 16'h0000);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 2'b00);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 16'h0000);
    check({tag, "_init_done"}, bus.init_done, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int strobes;
    int wr_before;
    bit seen;

    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = 16'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[10'h0FE] = 16'h5300;
    ref_mem[10'h0FE] = 16'h5300;

    // Reset values, then init_done on the first Idle strobe, then parked reads.
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("boot_init_done", bus.init_done, 1'b0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.ctrl_op_state) seen = 1;
    end
    check("first_strobe_seen", seen, 1'b1);
    @(negedge clk);
    check("init_done_rise", bus.init_done, 1'b1);
    for (int i = 0; i < 10 * PERIOD; i++) begin
      @(negedge clk);
      check("park_addr", bus.ctrl_addr, 11'h000);
      check("park_busy", bus.busy, 1'b0);
    end

    // Port 0 write reaches the bus with the right address and data.
    wr_before = bus_wr_count;
    req(0, 1'b1, 10'h200, 16'hA55A, 60, acc, strobes);
    check("wr_accepted", acc, 1'b1);
    repeat (PERIOD + 2) @(negedge clk);
    check("bus_wr_count", bus_wr_count, wr_before + 1);
    check("bus_wr_addr", last_wr_addr, 10'h200);
    check("bus_wr_data", last_wr_data, 16'hA55A);
    wait_drain();

    // Port 1 read of a known register.
    req(1, 1'b0, 10'h0FE, 16'h0000, 60, acc, strobes);
    check("rd_accepted", acc, 1'b1);
    wait_drain();

    // Both ports continuously valid: grants alternate starting with port 0.
    grant_log.delete();
    fork
      begin
        bit ac;
        int st;
        for (int k = 0; k < 3; k++) begin
          req(0, 1'b1, 10'h300 + 10'(k), 16'h1000 + 16'(k), 60, ac, st);
          check("alt_acc0", ac, 1'b1);
        end
      end
      begin
        bit ac;
        int st;
        for (int k = 0; k < 3; k++) begin
          req(1, 1'b0, 10'h300 + 10'(k), 16'h0000, 60, ac, st);
          check("alt_acc1", ac, 1'b1);
        end
      end
    join
    wait_drain();
    check("alt_count", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) check("alt_order", grant_log[k], k % 2);

    // Request raised mid ReadWrite of a parked read waits for the next strobe.
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.ctrl_op_state) seen = 1;
    end
    check("mid_sync", seen, 1'b1);
    @(posedge clk);
    req(0, 1'b0, 10'h200, 16'h0000, 60, acc, strobes);
    check("mid_accepted", acc, 1'b1);
    check("mid_strobes", strobes, 1);
    wait_drain();

    // Random traffic on both ports, including requests dropped before ready.
    fork
      begin
        bit ac;
        int st;
        for (int k = 0; k < 15; k++) begin
          req(0, 1'($urandom), 10'h100 + 10'($urandom_range(0, 7)), 16'($urandom),
              $urandom_range(1, 12), ac, st);
          repeat ($urandom_range(0, 4)) @(posedge clk);
        end
      end
      begin
        bit ac;
        int st;
        for (int k = 0; k < 15; k++) begin
          req(1, 1'($urandom), 10'h100 + 10'($urandom_range(0, 7)), 16'($urandom),
              $urandom_range(1, 12), ac, st);
          repeat ($urandom_range(0, 4)) @(posedge clk);
        end
      end
    join
    wait_drain();

    // Reset during a Busy read: the response is lost, reissue completes.
    req(1, 1'b0, 10'h0FE, 16'h0000, 60, acc, strobes);
    check("rst_rd_accepted", acc, 1'b1);
    @(negedge clk);
    check("rst_busy_before", bus.busy, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb0.delete();
    sb1.delete();
    last_grant = 1;
    @(negedge clk);
    check_reset_values("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rerst_init_done", bus.init_done, 1'b0);
    repeat (3 * PERIOD) @(negedge clk);
    check("reinit_done", bus.init_done, 1'b1);
    req(1, 1'b0, 10'h0FE, 16'h0000, 60, acc, strobes);
    check("reissue_accepted", acc, 1'b1);
    wait_drain();
    repeat (2 * PERIOD) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
